ifetch_unit: RTL and testbench

Per-core instruction fetch stage that sits directly upstream of the 8-core shared instruction-memory controller. It holds the core's fetch PC, requests one instruction byte at a time from the controller via a rden/acq handshake, and captures the broadcast RAM byte. Captured bytes are buffered with their PC in a small prefetch FIFO, and the core pops them with a valid/ready handshake. One instance per core; `mem_acq` and `mem_q` connect to that core's `acq` bit and its `Dq` byte lane.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_fifo.sv | 75 +++++++
 rtl/ifetch_unit.sv | 134 +++++++++++++
 tb/tb_ifetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and defaults for the per-core
// instruction fetch stage.
package ifetch_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [7:0]            instr;
        logic [ADDR_W_DEF-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: prefetch buffer of {byte, pc} entries with
// flush, simultaneous push/pop (legal when full) and count.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 data_i,
    input  logic                   pop_i,
    output entry_t                 data_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    entry_t          buf_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

    // Entry storage; a flush only rewinds pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (do_push && !flush_i) begin
            buf_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking; flush beats push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign data_o  = buf_q[rd_ptr_q];
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == FULL_CNT);

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: per-core fetch FSM that requests bytes from the
// shared instruction-memory controller and buffers them.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = DEPTH_DEF,
    parameter int                RD_LAT   = RD_LAT_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic              instr_valid,
    output logic [7:0]        instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_acq,
    input  logic [7:0]        mem_q
);

    typedef struct packed {
        logic [7:0]        instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [1:0]    LAT    = RD_LAT[1:0];
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              push;
    logic              pop;
    logic              room;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    entry_t            wr_entry;
    entry_t            head;

    // A redirect flushes the FIFO, so a same-cycle pop is void.
    assign pop  = instr_valid && instr_ready && !pc_load;
    // Room for another request once the current byte lands.
    assign room = pop || (fifo_count < ALMOST);

    assign wr_entry = '{instr: mem_q, pc: pc_q};

    // Next state, fetch PC and latency countdown.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pc_load || !fifo_full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_acq) begin
                    cnt_d   = LAT;
                    state_d = pc_load ? DROP : DATA;
                end else if (pc_load) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    if (pc_load) begin
                        state_d = IDLE;
                    end else begin
                        push    = 1'b1;
                        pc_d    = pc_q + 1'b1;
                        state_d = room ? REQ : IDLE;
                    end
                end else if (pc_load) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pc_load) begin
            pc_d = pc_load_val;
        end
    end

    // State, PC and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_rden = (state_q == REQ);
    assign mem_addr = pc_q;

    ifetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (pc_load),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .data_o  (head),
        .valid_o (instr_valid),
        .count_o (fifo_count),
        .full_o  (fifo_full)
    );

    assign instr    = head.instr;
    assign instr_pc = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scoreboard bench for ifetch_unit with
// a 2nd-cycle-grant controller model; unit 0 RD_LAT=1, unit 1 RD_LAT=2.
module tb_ifetch_unit;

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] pc;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pcl;
    logic [1:0] rdy;
    logic [1:0] valid;
    logic [1:0] rden;
    logic [1:0] acq;
    logic [7:0] pcv  [2];
    logic [7:0] ins  [2];
    logic [7:0] ipc  [2];
    logic [7:0] addr [2];
    logic [7:0] q    [2];

    ent_t sb0[$];
    ent_t sb1[$];
    int   gnt [2];
    logic gnt_now [2];
    int   n_asrt = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       acq_r;
        logic [7:0] d1;
        logic [7:0] d2;

        ifetch_unit #(
            .ADDR_W   (8),
            .DEPTH    (4),
            .RD_LAT   (g + 1),
            .RESET_PC (8'h00)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .pc_load     (pcl[g]),
            .pc_load_val (pcv[g]),
            .instr_valid (valid[g]),
            .instr       (ins[g]),
            .instr_pc    (ipc[g]),
            .instr_ready (rdy[g]),
            .mem_rden    (rden[g]),
            .mem_addr    (addr[g]),
            .mem_acq     (acq[g]),
            .mem_q       (q[g])
        );

        // Controller: grant in the 2nd request cycle, memory[n]=n+8'h10.
        always @(posedge clk) begin
            acq_r <= rden[g] & ~acq_r;
            d1    <= (rden[g] & acq_r) ? addr[g] + 8'h10 : 8'hEE;
            d2    <= d1;
        end

        assign acq[g] = acq_r;
        assign q[g]   = (g == 0) ? d1 : d2;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input int i);
        ent_t e;
        int   n;
        n = (i == 0) ? sb0.size() : sb1.size();
        chk($sformatf("sb_avail%0d", i), 32'(n != 0), 32'd1);
        if (n != 0) begin
            if (i == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk($sformatf("instr%0d", i), 32'(ins[i]), 32'(e.instr));
            chk($sformatf("instr_pc%0d", i), 32'(ipc[i]), 32'(e.pc));
        end
    endtask

    // Evaluate handshakes for the coming edge, then advance to next negedge.
    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            gnt_now[i] = rden[i] & acq[i];
            if (gnt_now[i]) gnt[i]++;
            if (valid[i] && rdy[i] && !pcl[i]) pop_chk(i);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int i, input int budget);
        int n;
        n = 0;
        while (((i == 0) ? sb0.size() : sb1.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("drain%0d", i),
            32'((i == 0) ? sb0.size() : sb1.size()), 32'd0);
    endtask

    task automatic wait_gnt(input int i, input int budget);
        int n;
        n = 0;
        gnt_now[i] = 1'b0;
        while (!gnt_now[i] && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("grant_seen%0d", i), 32'(gnt_now[i]), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        pcl = '0;
        rdy = '0;
        pcv[0] = 8'h00;
        pcv[1] = 8'h00;
        gnt[0] = 0;
        gnt[1] = 0;
        gnt_now[0] = 1'b0;
        gnt_now[1] = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_rden%0d", i), 32'(rden[i]), 32'd0);
            chk($sformatf("rst_addr%0d", i), 32'(addr[i]), 32'h00);
            chk($sformatf("rst_valid%0d", i), 32'(valid[i]), 32'd0);
            chk($sformatf("rst_instr%0d", i), 32'(ins[i]), 32'h00);
            chk($sformatf("rst_ipc%0d", i), 32'(ipc[i]), 32'h00);
        end

        rst_n = 1'b1;
        rdy[0] = 1'b1;
        for (int n = 0; n < 3; n++) sb0.push_back('{8'(n + 8'h10), 8'(n)});
        tick();
        chk("rden_after_release", 32'(rden[0]), 32'd1);
        chk("addr_after_release", 32'(addr[0]), 32'h00);
        drain(0, 40);
        rdy[0] = 1'b0;

        repeat (30) tick();
        chk("fill_grants", 32'(gnt[0]), 32'd7);
        chk("fill_rden_low", 32'(rden[0]), 32'd0);
        chk("fill_valid", 32'(valid[0]), 32'd1);

        sb0.push_back('{8'h13, 8'h03});
        rdy[0] = 1'b1;
        tick();
        rdy[0] = 1'b0;
        repeat (20) tick();
        chk("one_pop_grants", 32'(gnt[0]), 32'd8);
        chk("one_pop_rden_low", 32'(rden[0]), 32'd0);

        for (int n = 4; n < 8; n++) sb0.push_back('{8'(n + 8'h10), 8'(n)});
        rdy[0] = 1'b1;
        drain(0, 40);
        rdy[0] = 1'b0;
        repeat (15) tick();
        chk("pre_flush_valid", 32'(valid[0]), 32'd1);

        pcl[0] = 1'b1;
        pcv[0] = 8'hFE;
        rdy[0] = 1'b1;
        tick();
        pcl[0] = 1'b0;
        chk("flush_valid", 32'(valid[0]), 32'd0);
        sb0.push_back('{8'h0E, 8'hFE});
        sb0.push_back('{8'h0F, 8'hFF});
        sb0.push_back('{8'h10, 8'h00});
        drain(0, 60);
        rdy[0] = 1'b0;

        sb1.push_back('{8'h10, 8'h00});
        rdy[1] = 1'b1;
        tick();
        rdy[1] = 1'b0;
        wait_gnt(1, 20);
        pcl[1] = 1'b1;
        pcv[1] = 8'h80;
        tick();
        pcl[1] = 1'b0;
        chk("drop_flush_valid", 32'(valid[1]), 32'd0);
        repeat (2) tick();
        chk("drop_no_push", 32'(valid[1]), 32'd0);
        sb1.push_back('{8'h90, 8'h80});
        rdy[1] = 1'b1;
        drain(1, 40);
        rdy[1] = 1'b0;

        pcl[0] = 1'b1;
        pcv[0] = 8'h40;
        tick();
        pcl[0] = 1'b0;
        wait_gnt(0, 20);
        rst_n = 1'b0;
        #1;
        chk("rst_in_data_rden", 32'(rden[0]), 32'd0);
        chk("rst_in_data_valid", 32'(valid[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rel_addr", 32'(addr[0]), 32'h00);
        tick();
        chk("rst_first_rden", 32'(rden[0]), 32'd1);
        chk("rst_first_addr", 32'(addr[0]), 32'h00);
        sb0.push_back('{8'h10, 8'h00});
        rdy[0] = 1'b1;
        drain(0, 40);
        rdy[0] = 1'b0;

        for (int n = 0; n < 10 && !rden[0]; n++) tick();
        chk("rden_seen", 32'(rden[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_rden", 32'(rden[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
